// File: rtl/tri_diff_gen_if.sv
// Vertex input stream and triangle-difference output bundle.
// Shared by tri_diff_gen (slave) and its upstream/downstream peers (master).
interface tri_diff_gen_if;
    logic        vtx_valid;
    logic        vtx_ready;
    logic [31:0] vtx_data;
    logic        vtx_type;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    logic [31:0] diff_p1p2;
    logic [31:0] diff_p2p3;
    logic [31:0] diff_p3p1;
    logic        out_type;

    modport master (
        output vtx_valid, vtx_data, vtx_type, out_ready,
        input  vtx_ready, out_valid, p1, p2, p3,
        input  diff_p1p2, diff_p2p3, diff_p3p1, out_type
    );

    modport slave (
        input  vtx_valid, vtx_data, vtx_type, out_ready,
        output vtx_ready, out_valid, p1, p2, p3,
        output diff_p1p2, diff_p2p3, diff_p3p1, out_type
    );
endinterface

// File: rtl/tri_diff_gen.sv
// Triangle setup front end: loads three vertices, computes pairwise diffs on one subtractor.
// Define TRI_DIFF_SAT_EN for saturating subtraction; default wraps modulo 2^32.
module tri_diff_gen (
    input  logic          clk,
    input  logic          rst,
    tri_diff_gen_if.slave bus
);
    localparam logic [2:0] LOAD0 = 3'd0;
    localparam logic [2:0] LOAD1 = 3'd1;
    localparam logic [2:0] LOAD2 = 3'd2;
    localparam logic [2:0] SUB12 = 3'd3;
    localparam logic [2:0] SUB23 = 3'd4;
    localparam logic [2:0] SUB31 = 3'd5;
    localparam logic [2:0] OUT   = 3'd6;

    logic [2:0]  r_state;
    logic [31:0] r_p1, r_p2, r_p3;
    logic [31:0] r_d12, r_d23, r_d31;
    logic        r_type;

    logic        w_load;
    logic        w_acc;
    logic [31:0] w_a, w_b, w_diff;

    assign w_load = (r_state == LOAD0) || (r_state == LOAD1) ||
                    (r_state == LOAD2);
    assign w_acc  = w_load && bus.vtx_valid;

    // Operand select for the single shared subtractor.
    always_comb begin
        w_a = r_p1;
        w_b = r_p2;
        case (r_state)
            SUB23:   begin w_a = r_p2; w_b = r_p3; end
            SUB31:   begin w_a = r_p3; w_b = r_p1; end
            default: begin w_a = r_p1; w_b = r_p2; end
        endcase
    end

`ifdef TRI_DIFF_SAT_EN
    logic [32:0] w_ext;
    logic        w_ovf;

    // 33-bit difference clamped to the signed 32-bit range.
    always_comb begin
        w_ext  = {w_a[31], w_a} - {w_b[31], w_b};
        w_ovf  = w_ext[32] ^ w_ext[31];
        w_diff = w_ext[31:0];
        if (w_ovf)
            w_diff = w_ext[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
`else
    assign w_diff = w_a - w_b;
`endif

    // Sequencer: load three vertices, three subtract cycles, hold bundle until taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD0;
            r_p1    <= '0;
            r_p2    <= '0;
            r_p3    <= '0;
            r_d12   <= '0;
            r_d23   <= '0;
            r_d31   <= '0;
            r_type  <= 1'b0;
        end else begin
            case (r_state)
                LOAD0: if (w_acc) begin
                    r_p1    <= bus.vtx_data;
                    r_type  <= bus.vtx_type;
                    r_state <= LOAD1;
                end
                LOAD1: if (w_acc) begin
                    r_p2    <= bus.vtx_data;
                    r_state <= LOAD2;
                end
                LOAD2: if (w_acc) begin
                    r_p3    <= bus.vtx_data;
                    r_state <= SUB12;
                end
                SUB12: begin
                    r_d12   <= w_diff;
                    r_state <= SUB23;
                end
                SUB23: begin
                    r_d23   <= w_diff;
                    r_state <= SUB31;
                end
                SUB31: begin
                    r_d31   <= w_diff;
                    r_state <= OUT;
                end
                OUT: if (bus.out_ready) r_state <= LOAD0;
                default: r_state <= LOAD0;
            endcase
        end
    end

    assign bus.vtx_ready = w_load;
    assign bus.out_valid = (r_state == OUT);
    assign bus.p1        = r_p1;
    assign bus.p2        = r_p2;
    assign bus.p3        = r_p3;
    assign bus.diff_p1p2 = r_d12;
    assign bus.diff_p2p3 = r_d23;
    assign bus.diff_p3p1 = r_d31;
    assign bus.out_type  = r_type;
endmodule

// File: tb/tb_tri_diff_gen.sv
// Self-checking bench for tri_diff_gen: directed cases plus randomized triangles
// checked against an arithmetic reference model.
module tb_tri_diff_gen;
    logic clk;
    logic rst;
    int   nchk;
    int   nerr;
    int   cyc;

    tri_diff_gen_if bus ();

    tri_diff_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          xfer_cyc[$];
    logic [31:0] xfer_d12[$];
    logic        xfer_typ[$];

    // Transfer monitor: cycle number and payload of each accepted bundle.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            xfer_cyc.push_back(cyc);
            xfer_d12.push_back(bus.diff_p1p2);
            xfer_typ.push_back(bus.out_type);
        end
    end

    localparam longint MAXV = 64'sd2147483647;
    localparam longint MINV = -64'sd2147483648;

    function automatic logic [31:0] ref_sub(input logic [31:0] a,
                                            input logic [31:0] b);
        longint r;
        r = longint'($signed(a)) - longint'($signed(b));
`ifdef TRI_DIFF_SAT_EN
        if (r > MAXV) r = MAXV;
        if (r < MINV) r = MINV;
`endif
        return r[31:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cmp(input string tag, input logic [31:0] e1,
                       input logic [31:0] e2, input logic [31:0] e3,
                       input logic et);
        check({tag, ".p1"}, bus.p1, e1);
        check({tag, ".p2"}, bus.p2, e2);
        check({tag, ".p3"}, bus.p3, e3);
        check({tag, ".d12"}, bus.diff_p1p2, ref_sub(e1, e2));
        check({tag, ".d23"}, bus.diff_p2p3, ref_sub(e2, e3));
        check({tag, ".d31"}, bus.diff_p3p1, ref_sub(e3, e1));
        check({tag, ".type"}, {31'd0, bus.out_type}, {31'd0, et});
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send(input logic [31:0] d, input logic t);
        int n;
        n = 0;
        bus.vtx_valid = 1'b1;
        bus.vtx_data  = d;
        bus.vtx_type  = t;
        while (bus.vtx_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("send_timeout", 32'd0, 32'd1);
        @(negedge clk);
        bus.vtx_valid = 1'b0;
        bus.vtx_data  = $urandom;
        bus.vtx_type  = $urandom_range(0, 1);
    endtask

    task automatic recv(input string tag, input int stall,
                        input logic [31:0] e1, input logic [31:0] e2,
                        input logic [31:0] e3, input logic et,
                        output int lat);
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        check({tag, ".valid"}, {31'd0, bus.out_valid}, 32'd1);
        for (int i = 0; i < stall; i++) begin
            check({tag, ".stall_rdy"}, {31'd0, bus.vtx_ready}, 32'd0);
            check({tag, ".stall_vld"}, {31'd0, bus.out_valid}, 32'd1);
            cmp({tag, ".hold"}, e1, e2, e3, et);
            @(negedge clk);
        end
        cmp(tag, e1, e2, e3, et);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, ".post_vld"}, {31'd0, bus.out_valid}, 32'd0);
        check({tag, ".post_rdy"}, {31'd0, bus.vtx_ready}, 32'd1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic [31:0] a, b, c;
        logic        t;
        nchk = 0;
        nerr = 0;
        cyc  = 0;
        rst  = 1'b1;
        bus.vtx_valid = 1'b0;
        bus.vtx_data  = '0;
        bus.vtx_type  = 1'b0;
        bus.out_ready = 1'b0;
        idle(3);
        rst = 1'b0;

        // Reset state
        check("rst.rdy", {31'd0, bus.vtx_ready}, 32'd1);
        check("rst.vld", {31'd0, bus.out_valid}, 32'd0);
        cmp("rst", 32'd0, 32'd0, 32'd0, 1'b0);

        // Basic, with spec constants and latency
        send(32'd10, 1'b1);
        send(32'd3, 1'b0);
        send(32'd7, 1'b0);
        check("basic.d12k", 32'h0000_0007, ref_sub(32'd10, 32'd3));
        recv("basic", 0, 32'd10, 32'd3, 32'd7, 1'b1, lat);
        check("basic.lat", lat, 32'd3);

        // Backpressure
        send(32'd100, 1'b0);
        send(32'hFFFF_FF00, 1'b1);
        send(32'd5, 1'b1);
        recv("bp", 5, 32'd100, 32'hFFFF_FF00, 32'd5, 1'b0, lat);

        // Input gaps
        idle(2);
        send(32'd10, 1'b1);
        idle(2);
        send(32'd3, 1'b0);
        idle(2);
        send(32'd7, 1'b1);
        recv("gaps", 0, 32'd10, 32'd3, 32'd7, 1'b1, lat);
        check("gaps.d23", bus.diff_p2p3, 32'hFFFF_FFFC);
        check("gaps.d31", bus.diff_p3p1, 32'hFFFF_FFFD);

        // Overflow
        send(32'h7FFF_FFFF, 1'b0);
        send(32'h8000_0000, 1'b0);
        send(32'h0000_0000, 1'b0);
        recv("ovf", 0, 32'h7FFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, lat);
        check("ovf.d23k", bus.diff_p2p3, 32'h8000_0000);
        check("ovf.d31k", bus.diff_p3p1, 32'h8000_0001);
`ifdef TRI_DIFF_SAT_EN
        check("ovf.d12k", bus.diff_p1p2, 32'h7FFF_FFFF);
`else
        check("ovf.d12k", bus.diff_p1p2, 32'hFFFF_FFFF);
`endif

        // Reset during SUB23
        send(32'd9, 1'b1);
        send(32'd4, 1'b1);
        send(32'd2, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mrst.vld", {31'd0, bus.out_valid}, 32'd0);
        check("mrst.rdy", {31'd0, bus.vtx_ready}, 32'd1);
        cmp("mrst", 32'd0, 32'd0, 32'd0, 1'b0);
        rst = 1'b0;
        idle(6);
        check("mrst.novld", {31'd0, bus.out_valid}, 32'd0);
        send(32'd1, 1'b0);
        send(32'd2, 1'b0);
        send(32'd3, 1'b0);
        recv("after_rst", 0, 32'd1, 32'd2, 32'd3, 1'b0, lat);
        check("after_rst.d31k", bus.diff_p3p1, 32'h0000_0002);

        // Back-to-back
        xfer_cyc.delete();
        xfer_d12.delete();
        xfer_typ.delete();
        bus.out_ready = 1'b1;
        send(32'd50, 1'b1);
        send(32'd20, 1'b0);
        send(32'd30, 1'b0);
        send(32'd1, 1'b0);
        send(32'd8, 1'b1);
        send(32'd2, 1'b1);
        n = 0;
        while (xfer_cyc.size() < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        bus.out_ready = 1'b0;
        check("b2b.count", xfer_cyc.size(), 32'd2);
        if (xfer_cyc.size() >= 2) begin
            check("b2b.period", xfer_cyc[1] - xfer_cyc[0], 32'd7);
            check("b2b.type0", {31'd0, xfer_typ[0]}, 32'd1);
            check("b2b.type1", {31'd0, xfer_typ[1]}, 32'd0);
            check("b2b.d12_0", xfer_d12[0], 32'd30);
            check("b2b.d12_1", xfer_d12[1], 32'hFFFF_FFF9);
        end

        // Randomized triangles
        for (int k = 0; k < 40; k++) begin
            a = $urandom;
            b = $urandom;
            c = $urandom;
            if (k % 5 == 0) a = 32'h7FFF_FFFF - $urandom_range(0, 3);
            if (k % 7 == 0) b = 32'h8000_0000 + $urandom_range(0, 3);
            t = $urandom_range(0, 1);
            idle($urandom_range(0, 2));
            send(a, t);
            idle($urandom_range(0, 2));
            send(b, ~t);
            idle($urandom_range(0, 2));
            send(c, ~t);
            recv("rnd", $urandom_range(0, 3), a, b, c, t, lat);
        end

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
